dbus_master: RTL and testbench
==============================

// Module: dbus_master
// PURPOSE
//  Data-bus master for the load/store path. Sits directly downstream of the store-lane
//  select stage, whose byte enables and lane-aligned write data it takes, and directly
//  upstream of the load-extract stage, which it feeds raw 32-bit read words.
//  Runs a registered request/grant/response handshake on the external data bus, stalls
//  the core until each access completes, and bounds every access with a timeout.
// PARAMETERS
//  TIMEOUT  255  max bus cycles spent in REQ+WAIT before abort; 0 = timeout disabled
//  (REG_LEN = 32 from the core package; not overridable here)
// PORTS
//  clk          in   1        core clock; all state on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  req_valid    in   1        core requests a memory access; held stable while stall=1
//  req_we       in   1        1 = store, 0 = load
//  req_addr     in   32       byte address from ALU
//  req_be       in   4        byte enables from the store-lane select stage (loads: ignored)
//  req_wdata    in   32       lane-aligned store data from the store-lane select stage
//  stall        out  1        hold core pipeline
//  rdata        out  32       raw read word to the load-extract stage; valid when done=1
//  done         out  1        one-cycle completion pulse
//  err          out  1        with done: access aborted by timeout
//  bus_req      out  1        bus request
//  bus_we       out  1        bus write
//  bus_addr     out  32       word-aligned address, {req_addr[31:2],2'b00}
//  bus_be       out  4        bus byte enables (loads drive 4'b1111)
//  bus_wdata    out  32       bus write data
//  bus_gnt      in   1        slave accepts the request in this cycle
//  bus_rvalid   in   1        read data valid (only in a cycle after the grant)
//  bus_rdata    in   32       read data
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; every output 0; timeout counter 0.
//  All bus_* outputs, rdata, done and err are registered. No combinational path runs
//  from bus_* inputs to core outputs.
//  stall = req_valid & (state != DONE); this is combinational from req_valid only.
//  FSM:
//   IDLE: req_valid=1 -> capture we/addr/be/wdata into bus_* regs, bus_req<=1, ->REQ.
//         Loads drive bus_be 4'b1111 and bus_wdata 0.
//   REQ:  bus_gnt=1 -> bus_req<=0. A store goes to DONE. A load goes to WAIT.
//         Otherwise hold bus_* stable.
//   WAIT: bus_rvalid=1 -> rdata<=bus_rdata, ->DONE. bus_rvalid is ignored in IDLE, REQ
//         and DONE.
//   DONE: done=1 for exactly this cycle; stall=0, so the core advances; ->IDLE.
//         rdata holds its value until the next load completes.
//  Timeout: the counter clears on IDLE->REQ and increments each cycle in REQ or WAIT.
//   When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without the completing event:
//   bus_req<=0, rdata<=0, err<=1, ->DONE. err clears on leaving DONE.
//   The counter saturates and does not wrap.
//  Minimum latency, measured from the first req_valid cycle to the done cycle:
//   store = 2 cycles, load = 3 cycles.
//  Back-to-back requests: a new request is accepted in the IDLE cycle after DONE.
//   There is always at least one idle bus cycle between accesses.
//  If req_valid drops while stall=1 (a protocol violation), the access in flight still
//   completes and done pulses. Nothing new is issued.
//  Reset mid-access aborts it immediately. bus_req drops asynchronously and there is
//   no done pulse.
//  req_addr[1:0] is not checked. Alignment belongs to the upstream select stage.
// TESTING
//  Store with gnt tied 1, addr 0x104, be 0011, wdata 0x0000BEEF -> bus_req high for 1
//   cycle with bus_addr 0x104; done in cycle 2; stall high in cycles 0-1 only.
//  Store with gnt delayed 3 cycles -> bus_addr/be/wdata stable throughout; done on the
//   cycle after the gnt.
//  Load with gnt immediate and rvalid 2 cycles later, rdata 0xCAFEF00D -> rdata=0xCAFEF00D
//   with done=1 and err=0; a stray rvalid in IDLE is ignored.
//  TIMEOUT=8 and gnt never asserted -> bus_req drops after 8 cycles; done=1, err=1,
//   rdata=0; the next request proceeds normally.
//  rst_n pulsed low while in WAIT -> all outputs 0 the same cycle; no done pulse;
//   IDLE on release.
//  Ten back-to-back alternating loads and stores -> each completes once and in order;
//   bus_req is never high in a DONE or IDLE cycle.

Source files
------------

// File: rtl/dbus_master.sv
// Data-bus master: registered request/grant/response handshake with per-access timeout.
// Stalls the core until each load or store completes or is aborted.
module dbus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [3:0]  i_req_be,
  input  logic [31:0] i_req_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d, w_cnt_inc;
  logic              r_bus_req, w_bus_req_d;
  logic              r_bus_we, w_bus_we_d;
  logic [31:0]       r_bus_addr, w_bus_addr_d;
  logic [3:0]        r_bus_be, w_bus_be_d;
  logic [31:0]       r_bus_wdata, w_bus_wdata_d;
  logic [31:0]       r_rdata, w_rdata_d;
  logic              r_done, w_done_d;
  logic              r_err, w_err_d;
  logic              w_expired;
  logic              w_unused;

  // Byte offset is the select stage's concern; only the word address goes on the bus.
  assign w_unused = ^i_req_addr[1:0];

  // Counter saturates so a disabled timeout never wraps back into range.
  assign w_cnt_inc = (r_cnt == {CntW{1'b1}}) ? r_cnt : r_cnt + CntW'(1);
  assign w_expired = (TIMEOUT != 0) && ((32'(r_cnt) + 32'd1) >= TIMEOUT);

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_bus_req_d   = r_bus_req;
    w_bus_we_d    = r_bus_we;
    w_bus_addr_d  = r_bus_addr;
    w_bus_be_d    = r_bus_be;
    w_bus_wdata_d = r_bus_wdata;
    w_rdata_d     = r_rdata;
    w_done_d      = 1'b0;
    w_err_d       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          w_state_d     = StReq;
          w_cnt_d       = '0;
          w_bus_req_d   = 1'b1;
          w_bus_we_d    = i_req_we;
          w_bus_addr_d  = {i_req_addr[31:2], 2'b00};
          w_bus_be_d    = i_req_we ? i_req_be : 4'hF;
          w_bus_wdata_d = i_req_we ? i_req_wdata : 32'h0;
        end
      end
      StReq: begin
        w_cnt_d = w_cnt_inc;
        if (i_bus_gnt) begin
          w_bus_req_d = 1'b0;
          if (r_bus_we) begin
            w_state_d = StDone;
            w_done_d  = 1'b1;
          end else begin
            w_state_d = StWait;
          end
        end else if (w_expired) begin
          w_bus_req_d = 1'b0;
          w_rdata_d   = 32'h0;
          w_err_d     = 1'b1;
          w_done_d    = 1'b1;
          w_state_d   = StDone;
        end
      end
      StWait: begin
        w_cnt_d = w_cnt_inc;
        if (i_bus_rvalid) begin
          w_rdata_d = i_bus_rdata;
          w_done_d  = 1'b1;
          w_state_d = StDone;
        end else if (w_expired) begin
          w_rdata_d = 32'h0;
          w_err_d   = 1'b1;
          w_done_d  = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_be    <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_rdata     <= 32'h0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_bus_req   <= w_bus_req_d;
      r_bus_we    <= w_bus_we_d;
      r_bus_addr  <= w_bus_addr_d;
      r_bus_be    <= w_bus_be_d;
      r_bus_wdata <= w_bus_wdata_d;
      r_rdata     <= w_rdata_d;
      r_done      <= w_done_d;
      r_err       <= w_err_d;
    end
  end

  assign o_stall     = i_req_valid & (r_state != StDone);
  assign o_rdata     = r_rdata;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_bus_req   = r_bus_req;
  assign o_bus_we    = r_bus_we;
  assign o_bus_addr  = r_bus_addr;
  assign o_bus_be    = r_bus_be;
  assign o_bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_dbus_master.sv
// Bench for dbus_master: table of accesses against a cycle-driven slave, scoreboard on done,
// plus hand sequences for mid-access reset and a dropped request.
module tb_dbus_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, bus_gnt, bus_rvalid;
  logic [31:0] req_addr, req_wdata, bus_rdata;
  logic [3:0]  req_be;
  logic        stall, done, err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          g;      // REQ cycles before gnt
    int          r;      // cycles from gnt to rvalid
    logic [31:0] brd;
    bit          stray;  // junk rvalid while waiting for gnt
    bit          b2b;    // next access follows with no gap
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[17];
  exp_t sb_q[$];

  dbus_master #(.TIMEOUT(TO)) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_be    (req_be),
    .i_req_wdata (req_wdata),
    .o_stall     (stall),
    .o_rdata     (rdata),
    .o_done      (done),
    .o_err       (err),
    .o_bus_req   (bus_req),
    .o_bus_we    (bus_we),
    .o_bus_addr  (bus_addr),
    .o_bus_be    (bus_be),
    .o_bus_wdata (bus_wdata),
    .i_bus_gnt   (bus_gnt),
    .i_bus_rvalid(bus_rvalid),
    .i_bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input int g, input int r,
                              input logic [31:0] brd, input bit stray, input bit b2b,
                              input logic [31:0] ea, input logic [3:0] ebe,
                              input logic [31:0] ewd, input int lat, input logic [31:0] erd,
                              input logic eerr);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wd; v.g = g; v.r = r; v.brd = brd;
    v.stray = stray; v.b2b = b2b; v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ewd;
    v.exp_lat = lat; v.exp_rdata = erd; v.exp_err = eerr;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int   c;
    int   last_req;
    bit   seen;
    exp_t e;
    e.lat = v.exp_lat; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb_q.push_back(e);
    last_req = (1 + v.g < TO) ? 1 + v.g : TO;
    c = 0;
    seen = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_be = v.be; req_wdata = v.wdata;
    while (!seen && c <= v.exp_lat + 4) begin
      bus_gnt = (c == 1 + v.g);
      if (!v.we && c == 1 + v.g + v.r) begin
        bus_rvalid = 1'b1; bus_rdata = v.brd;
      end else if (v.stray && c >= 1 && c <= v.g) begin
        bus_rvalid = 1'b1; bus_rdata = 32'hDEADDEAD;
      end else begin
        bus_rvalid = 1'b0; bus_rdata = $urandom;
      end
      @(negedge clk);
      chk1("stall", stall, c != v.exp_lat);
      chk1("bus_req", bus_req, c >= 1 && c <= last_req);
      if (c >= 1 && c <= last_req) begin
        chk("bus_addr", bus_addr, v.exp_addr);
        chk("bus_be", {28'h0, bus_be}, {28'h0, v.exp_be});
        chk("bus_wdata", bus_wdata, v.exp_wdata);
        chk1("bus_we", bus_we, v.we);
      end
      if (done) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL sb_empty got=done expected=none");
        end else begin
          e = sb_q.pop_front();
          chk("latency", 32'(c), 32'(e.lat));
          chk("rdata", rdata, e.rdata);
          chk1("err", err, e.err);
        end
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    if (!seen) begin
      n_chk++; n_err++;
      $display("FAIL done_missing got=none expected=done_by_cycle_%0d", v.exp_lat);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic idle(input int n, input logic [31:0] exp_rd, input bit stray);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; bus_gnt = stray; bus_rvalid = stray; bus_rdata = 32'h5EEDF00D;
      @(negedge clk);
      chk1("idle_done", done, 1'b0);
      chk1("idle_bus_req", bus_req, 1'b0);
      chk1("idle_stall", stall, 1'b0);
      chk("idle_rdata", rdata, exp_rd);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_stall"}, stall, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_bus_req"}, bus_req, 1'b0);
    chk1({tag, "_bus_we"}, bus_we, 1'b0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_bus_addr"}, bus_addr, 32'h0);
    chk({tag, "_bus_be"}, {28'h0, bus_be}, 32'h0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we_l;
    int          g_l, r_l, lat_l;
    logic [31:0] a_l, wd_l, brd_l, last_rd;
    logic [3:0]  be_l;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_be = 4'h0;
    req_wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    //            we addr          be    wdata         g    r    brd           st b2b
    //            exp_addr      exp_be exp_wdata    lat rdata        err
    vecs[0] = mk(1, 32'h104,      4'h3, 32'h0000BEEF, 0,   0,   32'h0,        0, 0,
                 32'h104,      4'h3, 32'h0000BEEF, 2, 32'h0,        0);
    vecs[1] = mk(1, 32'h20000013, 4'h8, 32'hAA000000, 3,   0,   32'h0,        0, 0,
                 32'h20000010, 4'h8, 32'hAA000000, 5, 32'h0,        0);
    vecs[2] = mk(0, 32'h40,       4'h0, 32'h12121212, 0,   2,   32'hCAFEF00D, 0, 0,
                 32'h40,       4'hF, 32'h0,        4, 32'hCAFEF00D, 0);
    vecs[3] = mk(1, 32'h88,       4'hF, 32'h11223344, 255, 0,   32'h0,        0, 0,
                 32'h88,       4'hF, 32'h11223344, 9, 32'h0,        1);
    vecs[4] = mk(0, 32'h1FE,      4'h5, 32'h77777777, 1,   1,   32'h12345678, 1, 0,
                 32'h1FC,      4'hF, 32'h0,        4, 32'h12345678, 0);
    vecs[5] = mk(0, 32'h300,      4'h0, 32'h0,        2,   255, 32'h0,        0, 0,
                 32'h300,      4'hF, 32'h0,        9, 32'h0,        1);
    vecs[6] = mk(1, 32'h11,       4'hC, 32'h5A5A0000, 0,   0,   32'h0,        0, 0,
                 32'h10,       4'hC, 32'h5A5A0000, 2, 32'h0,        0);
    last_rd = 32'h0;
    for (int i = 7; i < 17; i++) begin
      we_l  = (i % 2) == 0;
      g_l   = $urandom_range(0, 2);
      r_l   = $urandom_range(1, 2);
      a_l   = $urandom;
      be_l  = 4'($urandom_range(1, 15));
      wd_l  = $urandom;
      brd_l = $urandom | 32'h1;
      lat_l = we_l ? 2 + g_l : 2 + g_l + r_l;
      if (!we_l) last_rd = brd_l;
      vecs[i] = mk(we_l, a_l, be_l, wd_l, g_l, r_l, brd_l, 0, i != 16,
                   {a_l[31:2], 2'b00}, we_l ? be_l : 4'hF, we_l ? wd_l : 32'h0,
                   lat_l, last_rd, 0);
    end

    for (int i = 0; i < 17; i++) begin
      run_txn(vecs[i]);
      if (!vecs[i].b2b) idle(2, vecs[i].exp_rdata, !vecs[i].we);
    end

    // Reset while a load sits in WAIT: everything clears at once, no done follows.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h80; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    @(negedge clk);
    chk1("wait_no_done", done, 1'b0);
    chk("wait_rdata_held", rdata, last_rd);
    #1;
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    bus_rvalid = 1'b1; bus_rdata = 32'h77;
    @(negedge clk);
    chk1("midrst_no_done", done, 1'b0);
    rst_n = 1'b1; bus_rvalid = 1'b0;
    @(negedge clk);
    chk1("rel_bus_req", bus_req, 1'b0);
    chk1("rel_done", done, 1'b0);
    chk("rel_rdata", rdata, 32'h0);
    run_txn(mk(1, 32'hABE, 4'hF, 32'h01020304, 0, 0, 32'h0, 0, 0,
               32'hABC, 4'hF, 32'h01020304, 2, 32'h0, 0));
    idle(2, 32'h0, 0);

    // req_valid dropped mid-access: the store still completes, nothing new issues.
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      req_valid = (c == 0); req_we = 1'b1; req_addr = 32'h44; req_be = 4'hF;
      req_wdata = 32'h99; bus_gnt = (c == 3); bus_rvalid = 1'b0;
      @(negedge clk);
      chk1("drop_done", done, c == 4);
      chk1("drop_bus_req", bus_req, c >= 1 && c <= 3);
      chk1("drop_stall", stall, c == 0);
      chk1("drop_err", err, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
